receive_queue: RTL and testbench

- Receive-side buffer of the message unit. Accepts incoming messages from the post office and holds them in arrival order.
- Serves receive requests from the request decoder by matching source core ID and tag, oldest match first.
- Returns the matched payload to writeback. A request with no match waits in the block until a matching message arrives.

---
 rtl/receive_queue.sv | 170 +++++++++++++++++
 tb/tb_receive_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receive_queue.sv
// Receive-side message buffer: holds post office messages in arrival order and serves src/tag receive requests, oldest match first.
// Optional macro RECEIVE_QUEUE_ANY_SRC_EN lets a request's any_src flag match messages from every sender.
module receive_queue #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              postoffice_receive_queue_valid,
    output logic              receive_queue_postoffice_ready,
    input  logic [ID_W-1:0]   postoffice_receive_queue_src,
    input  logic [TAG_W-1:0]  postoffice_receive_queue_tag,
    input  logic [DATA_W-1:0] postoffice_receive_queue_data,
    input  logic              request_decoder_receive_queue_valid,
    output logic              receive_queue_request_decoder_ready,
    input  logic [ID_W-1:0]   request_decoder_receive_queue_src,
    input  logic [TAG_W-1:0]  request_decoder_receive_queue_tag,
    input  logic              request_decoder_receive_queue_any_src,
    output logic              receive_queue_writeback_valid,
    input  logic              writeback_receive_queue_ready,
    output logic [DATA_W-1:0] receive_queue_writeback_data,
    output logic [ID_W-1:0]   receive_queue_writeback_src
);

    localparam int CNT_W = $clog2(SIZE + 1);
    localparam int IDX_W = $clog2(SIZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

`ifdef RECEIVE_QUEUE_ANY_SRC_EN
    localparam logic ANY_SRC_EN = 1'b1;
`else
    localparam logic ANY_SRC_EN = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ID_W-1:0]   reqSrc_q, reqSrc_d;
    logic [TAG_W-1:0]  reqTag_q, reqTag_d;
    logic              reqAny_q, reqAny_d;
    logic [IDX_W-1:0]  matchIdx_q, matchIdx_d;

    logic [ID_W-1:0]   srcMem_q  [SIZE];
    logic [TAG_W-1:0]  tagMem_q  [SIZE];
    logic [DATA_W-1:0] dataMem_q [SIZE];

    logic [ID_W-1:0]   srcShift  [SIZE];
    logic [TAG_W-1:0]  tagShift  [SIZE];
    logic [DATA_W-1:0] dataShift [SIZE];

    logic              pushEn;
    logic              removeEn;
    logic [CNT_W-1:0]  tail;
    logic              matchFound;
    logic [IDX_W-1:0]  matchIdx;

    assign receive_queue_postoffice_ready      = (count_q < CNT_W'(SIZE));
    assign receive_queue_request_decoder_ready = (state_q == ST_IDLE);
    assign receive_queue_writeback_valid       = (state_q == ST_RESP);
    assign receive_queue_writeback_data        = dataMem_q[matchIdx_q];
    assign receive_queue_writeback_src         = srcMem_q[matchIdx_q];

    // Flush wins over a same-cycle writeback handshake, so the entry survives.
    assign pushEn   = postoffice_receive_queue_valid & receive_queue_postoffice_ready;
    assign removeEn = (state_q == ST_RESP) & writeback_receive_queue_ready & ~flush;
    assign tail     = count_q - CNT_W'(removeEn);
    assign count_d  = count_q + CNT_W'(pushEn) - CNT_W'(removeEn);

    // Scan downward so the lowest (oldest) matching index is the one left standing.
    always_comb begin
        matchFound = 1'b0;
        matchIdx   = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count_q) && (tagMem_q[i] == reqTag_q) &&
                ((srcMem_q[i] == reqSrc_q) || (reqAny_q && ANY_SRC_EN))) begin
                matchFound = 1'b1;
                matchIdx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SIZE - 1; i++) begin
            if (removeEn && (IDX_W'(i) >= matchIdx_q)) begin
                srcShift[i]  = srcMem_q[i+1];
                tagShift[i]  = tagMem_q[i+1];
                dataShift[i] = dataMem_q[i+1];
            end else begin
                srcShift[i]  = srcMem_q[i];
                tagShift[i]  = tagMem_q[i];
                dataShift[i] = dataMem_q[i];
            end
        end
        srcShift[SIZE-1]  = srcMem_q[SIZE-1];
        tagShift[SIZE-1]  = tagMem_q[SIZE-1];
        dataShift[SIZE-1] = dataMem_q[SIZE-1];
    end

    always_comb begin
        state_d    = state_q;
        reqSrc_d   = reqSrc_q;
        reqTag_d   = reqTag_q;
        reqAny_d   = reqAny_q;
        matchIdx_d = matchIdx_q;
        case (state_q)
            ST_IDLE: begin
                if (request_decoder_receive_queue_valid) begin
                    reqSrc_d = request_decoder_receive_queue_src;
                    reqTag_d = request_decoder_receive_queue_tag;
                    reqAny_d = request_decoder_receive_queue_any_src;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (matchFound) begin
                    matchIdx_d = matchIdx;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (writeback_receive_queue_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            reqSrc_q   <= '0;
            reqTag_q   <= '0;
            reqAny_q   <= 1'b0;
            matchIdx_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reqSrc_q   <= reqSrc_d;
            reqTag_q   <= reqTag_d;
            reqAny_q   <= reqAny_d;
            matchIdx_q <= matchIdx_d;
        end
    end

    // Removal shift happens first; the arrival then lands at the post-shift tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (pushEn && (tail == CNT_W'(i))) begin
                srcMem_q[i]  <= postoffice_receive_queue_src;
                tagMem_q[i]  <= postoffice_receive_queue_tag;
                dataMem_q[i] <= postoffice_receive_queue_data;
            end else begin
                srcMem_q[i]  <= srcShift[i];
                tagMem_q[i]  <= tagShift[i];
                dataMem_q[i] <= dataShift[i];
            end
        end
    end

endmodule

// File: tb/tb_receive_queue.sv
// Self-checking bench for receive_queue: a queue-level reference model checked every cycle plus directed literal checks.
// Honours RECEIVE_QUEUE_ANY_SRC_EN to choose the expected any_src behaviour.
module tb_receive_queue;

    localparam int SIZE   = 4;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;
    localparam int TAG_W  = 8;

`ifdef RECEIVE_QUEUE_ANY_SRC_EN
    localparam bit ANY_EN = 1'b1;
`else
    localparam bit ANY_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              poValid = 1'b0;
    logic              poReady;
    logic [ID_W-1:0]   poSrc = '0;
    logic [TAG_W-1:0]  poTag = '0;
    logic [DATA_W-1:0] poData = '0;
    logic              rqValid = 1'b0;
    logic              rqReady;
    logic [ID_W-1:0]   rqSrc = '0;
    logic [TAG_W-1:0]  rqTag = '0;
    logic              rqAny = 1'b0;
    logic              wbValid;
    logic              wbReady = 1'b0;
    logic [DATA_W-1:0] wbData;
    logic [ID_W-1:0]   wbSrc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    receive_queue #(.SIZE(SIZE), .DATA_W(DATA_W), .ID_W(ID_W), .TAG_W(TAG_W)) dut (
        .clk                                   (clk),
        .rst                                   (rst),
        .flush                                 (flush),
        .postoffice_receive_queue_valid        (poValid),
        .receive_queue_postoffice_ready        (poReady),
        .postoffice_receive_queue_src          (poSrc),
        .postoffice_receive_queue_tag          (poTag),
        .postoffice_receive_queue_data         (poData),
        .request_decoder_receive_queue_valid   (rqValid),
        .receive_queue_request_decoder_ready   (rqReady),
        .request_decoder_receive_queue_src     (rqSrc),
        .request_decoder_receive_queue_tag     (rqTag),
        .request_decoder_receive_queue_any_src (rqAny),
        .receive_queue_writeback_valid         (wbValid),
        .writeback_receive_queue_ready         (wbReady),
        .receive_queue_writeback_data          (wbData),
        .receive_queue_writeback_src           (wbSrc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference model: message list in arrival order plus one outstanding request.
    typedef struct {
        logic [ID_W-1:0]   src;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } msg_t;

    msg_t             mq[$];
    int               mMode = 0;   // 0 free, 1 waiting for a match, 2 presenting a response
    logic [ID_W-1:0]  mSrc;
    logic [TAG_W-1:0] mTag;
    bit               mAny;
    int               mIdx;

    always @(negedge clk) begin
        bit removeNow;
        bit pushNow;
        msg_t m;
        if (rst) begin
            mq.delete();
            mMode = 0;
        end else begin
            checkOutput("model_po_ready", poReady, mq.size() < SIZE);
            checkOutput("model_req_ready", rqReady, mMode == 0);
            checkOutput("model_wb_valid", wbValid, mMode == 2);
            if (mMode == 2) begin
                checkOutput("model_wb_data", wbData, mq[mIdx].data);
                checkOutput("model_wb_src", wbSrc, mq[mIdx].src);
            end
            removeNow = (mMode == 2) && wbReady && !flush;
            pushNow   = poValid && (mq.size() < SIZE);
            case (mMode)
                0: if (rqValid) begin
                    mSrc = rqSrc; mTag = rqTag; mAny = rqAny && ANY_EN; mMode = 1;
                end
                1: begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].tag == mTag && (mAny || mq[i].src == mSrc)) begin
                            mIdx = i; mMode = 2; break;
                        end
                    end
                end
                2: if (wbReady) mMode = 0;
                default: mMode = 0;
            endcase
            if (flush) mMode = 0;
            if (removeNow) mq.delete(mIdx);
            if (pushNow) begin
                m.src = poSrc; m.tag = poTag; m.data = poData;
                mq.push_back(m);
            end
        end
    end

    task automatic applyStimulus(input logic [ID_W-1:0] s, input logic [TAG_W-1:0] t,
                                 input logic [DATA_W-1:0] d, output int accCyc);
        bit done = 0;
        @(posedge clk); #1;
        poValid = 1'b1; poSrc = s; poTag = t; poData = d;
        accCyc = -1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (poReady) begin accCyc = cyc; done = 1; end
        end
        if (!done) checkOutput("push_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        poValid = 1'b0;
    endtask

    task automatic sendReq(input logic [ID_W-1:0] s, input logic [TAG_W-1:0] t,
                           input logic a, output int accCyc);
        bit done = 0;
        @(posedge clk); #1;
        rqValid = 1'b1; rqSrc = s; rqTag = t; rqAny = a;
        accCyc = -1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (rqReady) begin accCyc = cyc; done = 1; end
        end
        if (!done) checkOutput("req_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        rqValid = 1'b0;
    endtask

    task automatic takeResp(input string name, input logic [DATA_W-1:0] expData,
                            input logic [ID_W-1:0] expSrc, input int expCyc);
        bit done = 0;
        @(posedge clk); #1;
        wbReady = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (wbValid) done = 1;
        end
        if (!done) begin
            checkOutput({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({name, "_data"}, wbData, expData);
            checkOutput({name, "_src"}, wbSrc, expSrc);
            if (expCyc >= 0) checkOutput({name, "_latency"}, cyc, expCyc);
        end
        @(posedge clk); #1;
        wbReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int k;
        bit done;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("t1_wb_valid", wbValid, 1'b0);
        checkOutput("t1_po_ready", poReady, 1'b1);
        checkOutput("t1_req_ready", rqReady, 1'b1);

        // Younger message matched before older one of a different sender
        applyStimulus(4'd2, 8'd5, 64'hA, k);
        applyStimulus(4'd3, 8'd5, 64'hB, k);
        sendReq(4'd3, 8'd5, 1'b0, c);
        takeResp("t2a", 64'hB, 4'd3, c + 2);
        sendReq(4'd2, 8'd5, 1'b0, c);
        takeResp("t2b", 64'hA, 4'd2, c + 2);

        // Same src/tag: oldest first
        applyStimulus(4'd1, 8'd7, 64'h11, k);
        applyStimulus(4'd1, 8'd7, 64'h22, k);
        sendReq(4'd1, 8'd7, 1'b0, c);
        takeResp("t3a", 64'h11, 4'd1, c + 2);
        sendReq(4'd1, 8'd7, 1'b0, c);
        takeResp("t3b", 64'h22, 4'd1, c + 2);

        // Waiting request completes only on a matching arrival
        sendReq(4'd1, 8'd7, 1'b0, c);
        applyStimulus(4'd2, 8'd7, 64'h30, k);
        repeat (3) begin
            @(negedge clk);
            checkOutput("t4_no_match_valid", wbValid, 1'b0);
        end
        applyStimulus(4'd1, 8'd7, 64'h33, k);
        takeResp("t4_match", 64'h33, 4'd1, k + 2);
        sendReq(4'd2, 8'd7, 1'b0, c);
        takeResp("t4_drain", 64'h30, 4'd2, c + 2);

        // Full queue holds the fifth message until a slot is freed
        for (int i = 0; i < 4; i++) applyStimulus(4'd0, 8'd1, 64'h50 + 64'(i), k);
        @(negedge clk);
        checkOutput("t5_full", poReady, 1'b0);
        @(posedge clk); #1;
        poValid = 1'b1; poSrc = 4'd0; poTag = 8'd1; poData = 64'h54;
        sendReq(4'd0, 8'd1, 1'b0, c);
        @(posedge clk); #1;
        wbReady = 1'b1;
        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (wbValid) done = 1;
        end
        checkOutput("t5_resp_seen", done, 1'b1);
        checkOutput("t5_resp_data", wbData, 64'h50);
        checkOutput("t5_still_full", poReady, 1'b0);
        @(posedge clk); #1;
        wbReady = 1'b0;
        @(negedge clk);
        checkOutput("t5_ready_back", poReady, 1'b1);
        @(posedge clk); #1;
        poValid = 1'b0;
        @(negedge clk);
        checkOutput("t5_full_again", poReady, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            sendReq(4'd0, 8'd1, 1'b0, c);
            takeResp("t5_drain", 64'h50 + 64'(i), 4'd0, c + 2);
        end

        // Flush during RESP keeps the entry; a concurrent push still lands
        applyStimulus(4'd4, 8'd2, 64'h44, k);
        sendReq(4'd4, 8'd2, 1'b0, c);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t6_resp_valid", wbValid, 1'b1);
        checkOutput("t6_resp_data", wbData, 64'h44);
        @(posedge clk); #1;
        flush = 1'b1;
        poValid = 1'b1; poSrc = 4'd5; poTag = 8'd3; poData = 64'h66;
        @(posedge clk); #1;
        flush = 1'b0;
        poValid = 1'b0;
        @(negedge clk);
        checkOutput("t6_flushed_valid", wbValid, 1'b0);
        checkOutput("t6_flushed_req_ready", rqReady, 1'b1);
        sendReq(4'd4, 8'd2, 1'b0, c);
        @(posedge clk); #1;
        flush = 1'b1;
        wbReady = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wbReady = 1'b0;
        @(negedge clk);
        checkOutput("t6_flush_prio_valid", wbValid, 1'b0);
        sendReq(4'd4, 8'd2, 1'b0, c);
        takeResp("t6_rerequest", 64'h44, 4'd4, c + 2);
        sendReq(4'd5, 8'd3, 1'b0, c);
        takeResp("t6_flush_push", 64'h66, 4'd5, c + 2);

        // any_src request for tag 9
        applyStimulus(4'd5, 8'd9, 64'h91, k);
        applyStimulus(4'd6, 8'd9, 64'h92, k);
        sendReq(4'd6, 8'd9, 1'b1, c);
`ifdef RECEIVE_QUEUE_ANY_SRC_EN
        takeResp("t7_any", 64'h91, 4'd5, c + 2);
        sendReq(4'd6, 8'd9, 1'b0, c);
        takeResp("t7_rest", 64'h92, 4'd6, c + 2);
`else
        takeResp("t7_any_ignored", 64'h92, 4'd6, c + 2);
        sendReq(4'd5, 8'd9, 1'b0, c);
        takeResp("t7_rest", 64'h91, 4'd5, c + 2);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
